// File: rtl/onehot_req_debouncer_pkg.sv
// Shared types for the request debouncer and the downstream 4-to-2 encoder.
package onehot_req_debouncer_pkg;

    localparam int N_LINES = 4;

    typedef logic [N_LINES-1:0] onehot_t;
    typedef logic [1:0]         code_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } out_state_t;

endpackage

// File: rtl/onehot_req_debouncer_if.sv
// Valid/ready event channel from the debouncer to the encoder.
interface onehot_req_debouncer_if;
    import onehot_req_debouncer_pkg::*;

    onehot_t out_onehot;
    logic    out_valid;
    logic    out_ready;

    modport master (output out_onehot, output out_valid, input out_ready);
    modport slave  (input out_onehot, input out_valid, output out_ready);

endinterface

// File: rtl/onehot_req_debouncer_line_debouncer.sv
// One request line: 2-flop synchroniser, stability counter, debounced level and press pulse.
module line_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             db;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // rise is combinational so the press lands in pend on the same edge db flips
    assign accept = (s2 != db) && (cnt == CNT_LAST);
    assign rise   = accept && s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            db  <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == db) begin
                cnt <= '0;
            end else if (accept) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/onehot_req_debouncer.sv
// Debounces N request lines and delivers each press as a one-hot event over valid/ready,
// arbitrating pending presses round-robin.
module onehot_req_debouncer
    import onehot_req_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  onehot_t                        in_raw,
    onehot_req_debouncer_if.master         bus,
    output logic                           overrun
);

    // state   | meaning
    // ST_IDLE | no event presented, out_valid=0
    // ST_HOLD | event presented on out_onehot, waiting for out_ready

    out_state_t state;
    onehot_t    press;
    onehot_t    pend;
    onehot_t    onehot_q;
    logic       valid_q;
    code_t      rr_ptr;

    onehot_t    win_oh;
    code_t      win_idx;
    logic       found;
    logic       grant_en;
    onehot_t    grant_oh;

    for (genvar i = 0; i < N_LINES; i++) begin : g_line
        line_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_line (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (in_raw[i]),
            .rise  (press[i])
        );
    end

    // rr_ptr holds the first index to search, i.e. last granted + 1
    always_comb begin
        code_t idx;
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < N_LINES; k++) begin
            idx = rr_ptr + code_t'(k);
            if (!found && pend[idx]) begin
                found       = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = idx;
            end
        end
    end

    assign grant_en = found && ((state == ST_IDLE) || bus.out_ready);
    assign grant_oh = grant_en ? win_oh : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pend     <= '0;
            rr_ptr   <= '0;
            onehot_q <= '0;
            valid_q  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            // a press on a line granted this edge re-arms it rather than overrunning
            pend    <= (pend & ~grant_oh) | press;
            overrun <= |(press & pend & ~grant_oh);

            case (state)
                ST_IDLE: begin
                    if (grant_en) begin
                        onehot_q <= win_oh;
                        valid_q  <= 1'b1;
                        rr_ptr   <= win_idx + code_t'(1);
                        state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        if (grant_en) begin
                            onehot_q <= win_oh;
                            rr_ptr   <= win_idx + code_t'(1);
                        end else begin
                            onehot_q <= '0;
                            valid_q  <= 1'b0;
                            state    <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    onehot_q <= '0;
                    valid_q  <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.out_onehot = onehot_q;
    assign bus.out_valid  = valid_q;

endmodule

// File: tb/tb_onehot_req_debouncer.sv
// Directed bench for onehot_req_debouncer with DEBOUNCE_CYCLES=4.
module tb_onehot_req_debouncer;
    import onehot_req_debouncer_pkg::*;

    typedef struct {
        onehot_t raw;
        logic    rdy;
        logic    v;
        onehot_t oh;
        logic    ov;
    } vec_t;

    logic    clk;
    logic    rst_n;
    onehot_t in_raw;
    logic    overrun;
    int      tests;
    int      fails;
    vec_t    vecs[$];

    onehot_req_debouncer_if bus ();

    onehot_req_debouncer #(
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_raw  (in_raw),
        .bus     (bus),
        .overrun (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic ev, input onehot_t eoh, input logic eov);
        tests++;
        if (bus.out_valid !== ev || bus.out_onehot !== eoh || overrun !== eov) begin
            fails++;
            $display("FAIL %s: got valid=%0b onehot=%b overrun=%0b, want valid=%0b onehot=%b overrun=%0b",
                     name, bus.out_valid, bus.out_onehot, overrun, ev, eoh, eov);
        end
    endtask

    function automatic void add(input onehot_t raw, input logic rdy, input logic v,
                                input onehot_t oh, input logic ov, input int n);
        vec_t r;
        r.raw = raw; r.rdy = rdy; r.v = v; r.oh = oh; r.ov = ov;
        for (int k = 0; k < n; k++) vecs.push_back(r);
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        rst_n         = 1'b0;
        in_raw        = 4'hF;
        bus.out_ready = 1'b1;

        // reset with all lines asserted; then all four debounce together and drain in RR order
        add(4'hF, 1'b1, 1'b0, 4'b0000, 1'b0, 6);
        add(4'hF, 1'b1, 1'b1, 4'b0001, 1'b0, 1);
        add(4'hF, 1'b1, 1'b1, 4'b0010, 1'b0, 1);
        add(4'hF, 1'b1, 1'b1, 4'b0100, 1'b0, 1);
        add(4'hF, 1'b1, 1'b1, 4'b1000, 1'b0, 1);
        add(4'hF, 1'b1, 1'b0, 4'b0000, 1'b0, 1);
        add(4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 7);
        // clean press on line 2: single event after edge 7, nothing more while held
        add(4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 6);
        add(4'b0100, 1'b1, 1'b1, 4'b0100, 1'b0, 1);
        add(4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 5);
        add(4'h0, 1'b1, 1'b0, 4'b0000, 1'b0, 7);

        tick();
        check("reset_edge1", 1'b0, 4'b0000, 1'b0);
        tick();
        check("reset_edge2", 1'b0, 4'b0000, 1'b0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            in_raw        = vecs[i].raw;
            bus.out_ready = vecs[i].rdy;
            tick();
            check($sformatf("table[%0d]", i), vecs[i].v, vecs[i].oh, vecs[i].ov);
        end

        // bounce on line 1: high 3, low 1, then stable; event timed from the last rise
        bus.out_ready = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            in_raw = (e <= 3 || e >= 5) ? 4'b0010 : 4'b0000;
            tick();
            check($sformatf("bounce_e%0d", e), e == 11, (e == 11) ? 4'b0010 : 4'b0000, 1'b0);
        end
        in_raw = 4'h0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            check($sformatf("bounce_rel%0d", e), 1'b0, 4'b0000, 1'b0);
        end

        // simultaneous presses behind a stalled output
        in_raw = 4'h0;
        bus.out_ready = 1'b0;
        do_reset();
        for (int e = 1; e <= 14; e++) begin
            onehot_t eoh;
            in_raw        = 4'b1011;
            bus.out_ready = (e >= 11);
            tick();
            eoh = (e >= 7 && e <= 10) ? 4'b0001 :
                  (e == 11)           ? 4'b0010 :
                  (e == 12)           ? 4'b1000 : 4'b0000;
            check($sformatf("simul_e%0d", e), eoh != 4'b0000, eoh, 1'b0);
        end
        in_raw = 4'h0;
        for (int e = 1; e <= 8; e++) tick();

        // overrun: line 0 pending behind stalled line 3, released and pressed again
        bus.out_ready = 1'b0;
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            onehot_t eoh;
            in_raw        = ((e >= 8 && e <= 13) || e >= 20) ? 4'b1001 : 4'b1000;
            bus.out_ready = (e >= 27);
            tick();
            eoh = (e >= 7 && e <= 26) ? 4'b1000 :
                  (e == 27)           ? 4'b0001 : 4'b0000;
            check($sformatf("overrun_e%0d", e), eoh != 4'b0000, eoh, e == 25);
        end

        // reset while an event is presented and another is pending
        in_raw        = 4'h0;
        bus.out_ready = 1'b0;
        do_reset();
        for (int e = 1; e <= 7; e++) begin
            in_raw = 4'b0011;
            tick();
        end
        check("midrst_pre", 1'b1, 4'b0001, 1'b0);
        in_raw = 4'h0;
        rst_n  = 1'b0;
        tick();
        check("midrst_assert", 1'b0, 4'b0000, 1'b0);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check($sformatf("midrst_after%0d", e), 1'b0, 4'b0000, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
